// File: rtl/phv_assembler_if.sv
// phv_assembler_if: beat-stream input and PHV output bundle of phv_assembler.
//   i_pkt_valid / i_pkt_data / i_pkt_last : packet beat stream (first byte in MSBs)
//   o_pkt_ready                           : beat accept
//   o_phv_out_valid / o_phv_out           : one-cycle PHV pulse toward the parser
// master = packet source / PHV sink, slave = the assembler.
`timescale 1ns/1ps
interface phv_assembler_if #(
    parameter int DATA_WIDTH = 256,
    parameter int PHV_WIDTH  = 1024
);
    logic                  i_pkt_valid;
    logic [DATA_WIDTH-1:0] i_pkt_data;
    logic                  i_pkt_last;
    logic                  o_pkt_ready;
    logic                  o_phv_out_valid;
    logic [PHV_WIDTH-1:0]  o_phv_out;

    modport master (
        output i_pkt_valid, i_pkt_data, i_pkt_last,
        input  o_pkt_ready, o_phv_out_valid, o_phv_out
    );

    modport slave (
        input  i_pkt_valid, i_pkt_data, i_pkt_last,
        output o_pkt_ready, o_phv_out_valid, o_phv_out
    );
endinterface

// File: rtl/phv_assembler.sv
// phv_assembler: packs the leading PHV_WIDTH bits of each packet beat stream
// into one PHV word and emits it as a single-cycle pulse for the parser.
// Beats past the PHV window are drained; such packets bump the truncation count.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : beat stream in (valid/ready/last), PHV pulse out
//   o_pkt_cnt      : PHVs emitted (wraps)
//   o_trunc_cnt    : packets longer than the PHV window (wraps)
`timescale 1ns/1ps
module phv_assembler #(
    parameter int PHV_WIDTH  = 1024,
    parameter int DATA_WIDTH = 256,
    localparam int BEATS          = PHV_WIDTH / DATA_WIDTH,
    localparam int BEAT_CNT_WIDTH = $clog2(BEATS) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    phv_assembler_if.slave     bus,
    output logic [31:0]        o_pkt_cnt,
    output logic [31:0]        o_trunc_cnt
);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_IDX = BEAT_CNT_WIDTH'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic                      ready_q;
    logic [BEAT_CNT_WIDTH-1:0] idx_q, idx_d;
    logic [PHV_WIDTH-1:0]      buf_p0, buf_d;
    logic [PHV_WIDTH-1:0]      phv_p1;
    logic                      vld_p1;
    logic [31:0]               pkt_cnt_p1;
    logic [31:0]               trunc_cnt_q;

    logic accept;
    logic emit;
    logic trunc_inc;
    logic load_first;
    logic store_beat;

    assign accept = bus.i_pkt_valid && ready_q;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!bus.i_pkt_last) begin
                        state_d = (BEATS == 1) ? DRAIN : FILL;
                    end
                end
                FILL: begin
                    if (bus.i_pkt_last) begin
                        state_d = IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.i_pkt_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: emit strobe, truncation strobe, buffer write controls
    always_comb begin
        emit       = 1'b0;
        trunc_inc  = 1'b0;
        load_first = 1'b0;
        store_beat = 1'b0;
        idx_d      = idx_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    load_first = 1'b1;
                    emit       = bus.i_pkt_last || (BEATS == 1);
                    idx_d      = BEAT_CNT_WIDTH'(1);
                end
                FILL: begin
                    store_beat = 1'b1;
                    emit       = bus.i_pkt_last || (idx_q == LAST_IDX);
                    idx_d      = idx_q + BEAT_CNT_WIDTH'(1);
                end
                DRAIN: begin
                    trunc_inc = bus.i_pkt_last;
                end
                default: ;
            endcase
        end
    end

    // First beat clears the whole buffer so nothing from the previous packet
    // survives; later beats only overwrite their own slot.
    always_comb begin
        buf_d = buf_p0;
        if (load_first) begin
            buf_d = '0;
            buf_d[PHV_WIDTH-1 -: DATA_WIDTH] = bus.i_pkt_data;
        end else if (store_beat) begin
            buf_d[PHV_WIDTH-1 - int'(idx_q)*DATA_WIDTH -: DATA_WIDTH] = bus.i_pkt_data;
        end
    end

    // Stage p0 -> p1: assembly buffer, PHV output register and counters.
    // The PHV is taken from buf_d so the completing beat is included with
    // one cycle of latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_q     <= 1'b0;
            idx_q       <= '0;
            buf_p0      <= '0;
            phv_p1      <= '0;
            vld_p1      <= 1'b0;
            pkt_cnt_p1  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            ready_q <= 1'b1;
            idx_q   <= idx_d;
            buf_p0  <= buf_d;
            vld_p1  <= emit;
            if (emit) begin
                phv_p1     <= buf_d;
                pkt_cnt_p1 <= pkt_cnt_p1 + 32'd1;
            end
            if (trunc_inc) begin
                trunc_cnt_q <= trunc_cnt_q + 32'd1;
            end
        end
    end

    assign bus.o_pkt_ready     = ready_q;
    assign bus.o_phv_out_valid = vld_p1;
    assign bus.o_phv_out       = phv_p1;
    assign o_pkt_cnt           = pkt_cnt_p1;
    assign o_trunc_cnt         = trunc_cnt_q;

endmodule

// File: tb/tb_phv_assembler.sv
`timescale 1ns/1ps
module tb_phv_assembler;
    localparam int DW   = 256;
    localparam int PW   = 1024;
    localparam int NB   = PW / DW;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pkt_cnt;
    logic [31:0] trunc_cnt;

    always #HALF clk = ~clk;

    phv_assembler_if #(.DATA_WIDTH(DW), .PHV_WIDTH(PW)) bus ();

    phv_assembler #(.PHV_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_pkt_cnt   (pkt_cnt),
        .o_trunc_cnt (trunc_cnt)
    );

    typedef struct {
        logic [PW-1:0] phv;
        logic [31:0]   cnt;
        time           t;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] cur[$];
    logic [31:0]   m_pkt;
    logic [31:0]   m_trunc;
    logic [PW-1:0] m_hold;
    int            n_vec  = 0;
    int            n_fail = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_phv(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < NB; k++) begin
                if (act[PW-1-k*DW -: DW] !== exp[PW-1-k*DW -: DW]) begin
                    $display("FAIL %s beat%0d: got %h, expected %h", nm, k,
                             act[PW-1-k*DW -: DW], exp[PW-1-k*DW -: DW]);
                    break;
                end
            end
        end
    endtask

    // Reference model: a packet is a list of beats; the PHV is the first NB
    // beats concatenated, first beat most significant, zero-padded on the right.
    task automatic model_beat(input logic [DW-1:0] d, input logic last);
        logic [PW-1:0] e;
        exp_t          x;
        cur.push_back(d);
        if (cur.size() <= NB && (last || cur.size() == NB)) begin
            e = '0;
            foreach (cur[k]) e = (e << DW) | PW'(cur[k]);
            e = e << (DW * (NB - cur.size()));
            m_pkt = m_pkt + 32'd1;
            x.phv = e;
            x.cnt = m_pkt;
            x.t   = $time + HALF;
            exp_q.push_back(x);
        end
        if (last) begin
            if (cur.size() > NB) m_trunc = m_trunc + 32'd1;
            cur.delete();
        end
    endtask

    // Monitor: every pulse must match the oldest expected PHV at the expected time.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.o_phv_out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got valid=1, expected valid=0 at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk32("pulse_time", 32'($time), 32'(e.t));
                    chk_phv("phv", bus.o_phv_out, e.phv);
                    chk32("pkt_cnt_at_pulse", pkt_cnt, e.cnt);
                    m_hold = e.phv;
                end
            end else begin
                chk_phv("phv_hold", bus.o_phv_out, m_hold);
            end
        end
    end

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.i_pkt_valid = 1'b1;
        bus.i_pkt_data  = d;
        bus.i_pkt_last  = last;
        while (bus.o_pkt_ready !== 1'b1) begin
            guard++;
            if (guard > 50) begin
                n_vec++;
                n_fail++;
                $display("FAIL ready_timeout: got ready=%b, expected 1", bus.o_pkt_ready);
                bus.i_pkt_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        model_beat(d, last);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_pkt_valid = 1'b0;
            bus.i_pkt_last  = 1'b0;
            bus.i_pkt_data  = rand_beat();
        end
    endtask

    task automatic send_rand_pkt(input int len);
        for (int i = 0; i < len; i++) send_beat(rand_beat(), (i == len - 1));
    endtask

    task automatic check_counts(input string tag);
        idle(3);
        chk32({tag, "_pkt_cnt"}, pkt_cnt, m_pkt);
        chk32({tag, "_trunc_cnt"}, trunc_cnt, m_trunc);
        chk32({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus.i_pkt_valid = 1'b0;
        bus.i_pkt_last  = 1'b0;
        #1;
        cur.delete();
        exp_q.delete();
        m_pkt   = '0;
        m_trunc = '0;
        m_hold  = '0;
        chk32("rst_ready", 32'(bus.o_pkt_ready), 32'd0);
        chk32("rst_valid", 32'(bus.o_phv_out_valid), 32'd0);
        chk_phv("rst_phv", bus.o_phv_out, '0);
        chk32("rst_pkt_cnt", pkt_cnt, 32'd0);
        chk32("rst_trunc_cnt", trunc_cnt, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk32("ready_before_edge", 32'(bus.o_pkt_ready), 32'd0);
        @(negedge clk);
        chk32("ready_after_release", 32'(bus.o_pkt_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ba, bb, bc, bd, b11, be, bf, bg, bh;
        ba  = {64{4'hA}};
        bb  = {64{4'hB}};
        bc  = {64{4'hC}};
        bd  = {64{4'hD}};
        b11 = {32{8'h11}};
        be  = {64{4'hE}};
        bf  = {64{4'hF}};
        bg  = {32{8'h5A}};
        bh  = {32{8'h3C}};
        rst_n           = 1'b0;
        bus.i_pkt_valid = 1'b0;
        bus.i_pkt_data  = '0;
        bus.i_pkt_last  = 1'b0;
        m_pkt   = '0;
        m_trunc = '0;
        m_hold  = '0;
        do_reset();

        // Full 4-beat packet
        send_beat(ba, 1'b0);
        send_beat(bb, 1'b0);
        send_beat(bc, 1'b0);
        send_beat(bd, 1'b1);
        check_counts("four_beat");

        // Single-beat packet
        send_beat(b11, 1'b1);
        check_counts("one_beat");

        // 6-beat packet: truncated after beat 4
        send_rand_pkt(6);
        check_counts("six_beat");

        // Back-to-back packets, no idle gap
        send_beat(be, 1'b0);
        send_beat(bf, 1'b1);
        send_beat(bg, 1'b1);
        check_counts("back_to_back");

        // Reset in the middle of a packet
        send_beat(ba, 1'b0);
        send_beat(bb, 1'b0);
        do_reset();
        send_beat(bh, 1'b1);
        check_counts("after_abort");

        // Packet counter wrap
        @(negedge clk);
        force dut.pkt_cnt_p1 = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_p1;
        m_pkt = 32'hFFFF_FFFF;
        send_rand_pkt(2);
        check_counts("wrap");

        // Randomized packets and gaps
        for (int p = 0; p < 60; p++) begin
            send_rand_pkt(int'($urandom_range(1, 7)));
            idle(int'($urandom_range(0, 2)));
        end
        check_counts("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/phv_assembler.md
Name: phv_assembler

Overview:
- Upstream neighbour of the three-stage parser.
- Accepts packets as a beat stream (valid/ready/last) and packs the leading PHV_WIDTH bits of each packet into one PHV word.
- Emits that word as a single-cycle valid pulse on the parser's PHV input (i_phv_in_valid / i_phv_in). Beats beyond the PHV window are drained and discarded.
- Keeps packet and truncation counters for the configuration/debug path.

Parameters:
- PHV_WIDTH, 1024, PHV width in bits; must be an integer multiple of DATA_WIDTH.
- DATA_WIDTH, 256, width of one stream beat in bits.
- BEATS, PHV_WIDTH/DATA_WIDTH, number of beats that fill one PHV (derived; do not override).
- BEAT_CNT_WIDTH, $clog2(BEATS)+1, width of the beat index counter (derived).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_pkt_valid  in  1  beat valid.
- i_pkt_data  in  DATA_WIDTH  beat data, network byte order, first byte in the MSBs.
- i_pkt_last  in  1  final beat of the packet; qualified by i_pkt_valid.
- o_pkt_ready  out  1  beat accept; a beat transfers when i_pkt_valid && o_pkt_ready.
- o_phv_out_valid  out  1  one-cycle pulse: o_phv_out holds a new PHV.
- o_phv_out  out  PHV_WIDTH  assembled PHV; connects to the parser's i_phv_in.
- o_pkt_cnt  out  32  PHVs emitted, wraps at 2^32.
- o_trunc_cnt  out  32  packets longer than PHV_WIDTH bits, wraps at 2^32.

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low. While reset is asserted: state=IDLE, beat index=0, buffer=0, o_pkt_ready=0, o_phv_out_valid=0, o_phv_out=0, both counters=0.
- o_pkt_ready is registered. It goes to 1 on the first clock after reset release and stays 1; the parser applies no backpressure.
- Beat placement: beat k (0-based) of a packet lands at buffer bits [PHV_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH]. Bits that no beat writes are 0.
- On the first beat of a packet, the buffer is loaded as {beat, zeros}. Stale data from the previous packet must never leak into the new PHV.
- IDLE, accepted beat:
  - last=1: emit; stay IDLE.
  - last=0, BEATS==1: emit; go to DRAIN.
  - last=0, BEATS>1: index=1; go to FILL.
- FILL, accepted beat at index i:
  - last=1: emit (zero-padded); go to IDLE.
  - last=0, i==BEATS-1: emit; go to DRAIN.
  - Otherwise: index=i+1; stay in FILL.
- DRAIN: accepted beats are discarded. On an accepted beat with last=1, increment o_trunc_cnt and go to IDLE.
- Emit: o_phv_out is registered and o_phv_out_valid pulses high for exactly one cycle.
  - Latency is 1 cycle from acceptance of the completing beat.
  - o_pkt_cnt increments in the same cycle as the pulse.
  - o_phv_out holds its value between pulses.
- Back-to-back packets: a first beat accepted in the cycle directly after a last beat is legal. Consecutive emit pulses are therefore possible on adjacent cycles, and each must carry its own correct PHV.
- Idle cycles: cycles with i_pkt_valid=0 change nothing.
- Reset mid-packet: partial PHV is discarded, nothing is emitted, and no counter increments. After release, the next beat is treated as the first beat of a new packet.
- Counter overflow: both counters wrap from 0xFFFFFFFF to 0.

Test Plan:
- Config DATA_WIDTH=256, PHV_WIDTH=1024.
  - 4-beat packet, beats 0xA..A/0xB..B/0xC..C/0xD..D with last on beat 4 -> one pulse 1 cycle later; o_phv_out={A,B,C,D}; o_pkt_cnt=1, o_trunc_cnt=0.
- Single-beat packet 0x11..11 with last=1 -> o_phv_out={0x11..11, 768'b0}; pulse width 1 cycle.
- 6-beat packet -> pulse after beat 4 carrying beats 1-4; beats 5-6 dropped; o_trunc_cnt=1 after beat 6; no second pulse.
- 2-beat packet {E,F} immediately followed by a 1-beat packet {G}, no idle gap -> pulses on adjacent cycles, {E,F,0,0} then {G,0,0,0}; no leakage of F into the second PHV.
- i_rst_n asserted after 2 beats of a 4-beat packet, released, then a 1-beat packet {H} -> no pulse for the aborted packet; next pulse = {H,0,0,0}; o_pkt_cnt=1.
- Force o_pkt_cnt to 0xFFFFFFFF, send one packet -> o_pkt_cnt=0; o_pkt_ready=0 during reset and 1 from the first cycle after release.
